// File: rtl/poly_stream_buf_pkg.sv
// Shared constants, FSM state encoding and index helpers for the polynomial
// coefficient stream buffer.
package poly_stream_buf_pkg;

    localparam int KYBER_Q     = 3329;
    localparam int COEFF_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Reverse the low 'depth' bits of x; bits above 'depth' come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] x, input int depth);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < depth) begin
                r[i] = x[depth-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/poly_stream_buf_coeff_reduce.sv
// Single conditional subtract of Q from one coefficient, plus a flag telling
// whether the input was already at or above 2Q (and so is still out of range).
module coeff_reduce #(
    parameter int WIDTH = 16,
    parameter int Q     = 3329
) (
    input  logic [WIDTH-1:0] val_i,
    output logic [WIDTH-1:0] red_o,
    output logic             ge2q_o
);

    logic [WIDTH:0]   diff;
    logic [WIDTH+1:0] ext;

    // The borrow out of the WIDTH+1 bit subtract doubles as the v < Q test.
    assign diff   = {1'b0, val_i} - (WIDTH+1)'(Q);
    assign ext    = {2'b00, val_i};
    assign red_o  = diff[WIDTH] ? val_i : diff[WIDTH-1:0];
    assign ge2q_o = (ext >= (WIDTH+2)'(2 * Q));

endmodule

// File: rtl/poly_stream_buf.sv
// Polynomial coefficient buffer: loads 2^DEPTH coefficients LANES per beat,
// optionally reducing mod Q on write, then streams them back in natural or
// bit-reversed order with backpressure and a completion pulse.
module poly_stream_buf
    import poly_stream_buf_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LANES = 2,
    parameter int WIDTH = COEFF_WIDTH,
    parameter int Q     = KYBER_Q
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   set,
    input  logic                   reduce_en,
    input  logic [LANES*WIDTH-1:0] din,
    input  logic                   din_valid,
    output logic                   din_ready,
    input  logic                   readout,
    input  logic                   bitrev_en,
    output logic [LANES*WIDTH-1:0] dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [DEPTH-1:0]       out_index,
    output logic                   full,
    output logic                   done,
    output logic                   err
);

    localparam int N        = 1 << DEPTH;
    localparam int NBEATS   = N / LANES;
    localparam int LG_LANES = $clog2(LANES);
    localparam logic [DEPTH-1:0] LAST_BEAT = DEPTH'(NBEATS - 1);

    state_e                 state_q, state_d;
    logic [DEPTH-1:0]       wr_cnt_q, rd_cnt_q, out_idx_q;
    logic                   reduce_q, bitrev_q, err_q, done_q;
    logic                   dout_valid_q, issued_all_q;
    logic [LANES*WIDTH-1:0] dout_q;
    logic [WIDTH-1:0]       mem [N];

    logic [WIDTH-1:0]       red_val [LANES];
    logic [WIDTH-1:0]       wr_data [LANES];
    logic [DEPTH-1:0]       wr_addr [LANES];
    logic [DEPTH-1:0]       rd_pos  [LANES];
    logic [DEPTH-1:0]       rd_addr [LANES];
    logic [LANES*WIDTH-1:0] rd_data;
    logic [LANES-1:0]       ge2q;

    logic set_go, drain_go, wr_fire, wr_last, rd_load, rd_last, last_accept;

    assign set_go      = set && (state_q == ST_IDLE || state_q == ST_FULL);
    assign drain_go    = readout && !set && (state_q == ST_FULL);
    assign wr_fire     = (state_q == ST_LOAD) && din_valid;
    assign wr_last     = (wr_cnt_q == LAST_BEAT);
    // A new beat is fetched whenever the output register is empty or being consumed.
    assign rd_load     = (state_q == ST_DRAIN) && !issued_all_q && (!dout_valid_q || dout_ready);
    assign rd_last     = (rd_cnt_q == LAST_BEAT);
    assign last_accept = (state_q == ST_DRAIN) && issued_all_q && dout_valid_q && dout_ready;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        coeff_reduce #(.WIDTH(WIDTH), .Q(Q)) u_reduce (
            .val_i  (din[k*WIDTH +: WIDTH]),
            .red_o  (red_val[k]),
            .ge2q_o (ge2q[k])
        );
        assign wr_data[k] = reduce_q ? red_val[k] : din[k*WIDTH +: WIDTH];
        assign wr_addr[k] = (wr_cnt_q << LG_LANES) | DEPTH'(k);
        assign rd_pos[k]  = (rd_cnt_q << LG_LANES) | DEPTH'(k);
        assign rd_addr[k] = bitrev_q ? DEPTH'(bitrev(32'(rd_pos[k]), DEPTH)) : rd_pos[k];
        assign rd_data[k*WIDTH +: WIDTH] = mem[rd_addr[k]];
    end

    // Next-state logic for the IDLE/LOAD/FULL/DRAIN controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (set_go) state_d = ST_LOAD;
            ST_LOAD:  if (wr_fire && wr_last) state_d = ST_FULL;
            ST_FULL:  if (set_go) state_d = ST_LOAD;
                      else if (drain_go) state_d = ST_DRAIN;
            ST_DRAIN: if (last_accept) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Counters, latched mode bits, sticky error and the registered output beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            out_idx_q    <= '0;
            reduce_q     <= 1'b0;
            bitrev_q     <= 1'b0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            issued_all_q <= 1'b0;
            dout_q       <= '0;
        end else begin
            done_q <= last_accept;
            if (set_go) begin
                wr_cnt_q <= '0;
                reduce_q <= reduce_en;
                err_q    <= 1'b0;
            end else if (drain_go) begin
                rd_cnt_q     <= '0;
                bitrev_q     <= bitrev_en;
                issued_all_q <= 1'b0;
                dout_valid_q <= 1'b0;
            end
            if (wr_fire) begin
                wr_cnt_q <= wr_last ? '0 : wr_cnt_q + 1'b1;
                if (reduce_q && (|ge2q)) err_q <= 1'b1;
            end
            if (rd_load) begin
                dout_q       <= rd_data;
                out_idx_q    <= rd_cnt_q << LG_LANES;
                dout_valid_q <= 1'b1;
                rd_cnt_q     <= rd_last ? '0 : rd_cnt_q + 1'b1;
                issued_all_q <= rd_last;
            end else if (dout_valid_q && dout_ready) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    // Coefficient storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int k = 0; k < LANES; k++) begin
                mem[wr_addr[k]] <= wr_data[k];
            end
        end
    end

    assign din_ready  = (state_q == ST_LOAD);
    assign full       = (state_q == ST_FULL);
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign out_index  = out_idx_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_poly_stream_buf.sv
// Scoreboard bench for poly_stream_buf (DEPTH=8, LANES=2, WIDTH=16).
module tb_poly_stream_buf;

    localparam int DEPTH = 8;
    localparam int LANES = 2;
    localparam int WIDTH = 16;
    localparam int N     = 256;
    localparam int NB    = 128;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        set = 1'b0, reduce_en = 1'b0, readout = 1'b0, bitrev_en = 1'b0;
    logic [31:0] din = '0;
    logic        din_valid = 1'b0, din_ready;
    logic [31:0] dout;
    logic        dout_valid, dout_ready = 1'b0;
    logic [7:0]  out_index;
    logic        full, done, err;

    int          total = 0;
    int          bad = 0;
    logic [39:0] sbq [$];
    logic [31:0] got [NB];
    int          acc_cnt = 0;
    int          done_cnt = 0;
    logic        stall_prev = 1'b0;
    logic [39:0] hold = '0;
    logic [15:0] coef [N];
    logic [15:0] expv [N];
    logic        err_trace [NB];

    poly_stream_buf #(.DEPTH(DEPTH), .LANES(LANES), .WIDTH(WIDTH), .Q(3329)) dut (
        .clk        (clk),
        .reset      (reset),
        .set        (set),
        .reduce_en  (reduce_en),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .readout    (readout),
        .bitrev_en  (bitrev_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .out_index  (out_index),
        .full       (full),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Monitor: pops the scoreboard on every accepted beat and checks stall stability.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                total++;
                if (!dout_valid || {out_index, dout} !== hold) begin
                    bad++;
                    $display("FAIL stall_hold actual=%0h/%0b required=%0h/1", {out_index, dout}, dout_valid, hold);
                end
            end
            if (dout_valid && dout_ready) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat actual=%0h required=none", {out_index, dout});
                end else begin
                    logic [39:0] e;
                    e = sbq.pop_front();
                    if ({out_index, dout} !== e) begin
                        bad++;
                        $display("FAIL beat%0d actual=%0h required=%0h", acc_cnt, {out_index, dout}, e);
                    end
                end
                if (acc_cnt < NB) got[acc_cnt] = dout;
                acc_cnt++;
            end
            stall_prev = dout_valid && !dout_ready;
            hold = {out_index, dout};
            if (done) done_cnt++;
        end
    end

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic red, input bit gaps, input bit with_ro);
        int  beat;
        int  guard;
        bit  acc;
        set = 1'b1; reduce_en = red; readout = with_ro;
        tick();
        set = 1'b0; reduce_en = 1'b0; readout = 1'b0;
        check("load_entry_ready", 40'(din_ready), 40'd1);
        check("load_entry_full", 40'(full), 40'd0);
        check("load_entry_nodrain", 40'(dout_valid), 40'd0);
        check("load_entry_err", 40'(err), 40'd0);
        beat = 0; guard = 0;
        while (beat < NB && guard < 2000) begin
            din = {coef[2*beat+1], coef[2*beat]};
            din_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (beat == NB-1 && din_valid) check("full_before_last", 40'(full), 40'd0);
            acc = din_valid && din_ready;
            tick();
            guard++;
            if (acc) begin
                err_trace[beat] = err;
                beat++;
            end
        end
        din_valid = 1'b0;
        if (guard >= 2000) begin
            total++; bad++;
            $display("FAIL load_timeout actual=%0d required=%0d", beat, NB);
        end
        check("full_after_load", 40'(full), 40'd1);
        check("ready_in_full", 40'(din_ready), 40'd0);
    endtask

    task automatic drain(input bit brev, input bit rnd, input int abort_at);
        int guard;
        int d0;
        acc_cnt = 0;
        d0 = done_cnt;
        for (int j = 0; j < NB; j++) begin
            logic [7:0] p0, p1;
            p0 = 8'(2*j);
            p1 = 8'(2*j+1);
            if (brev) begin
                p0 = rev8(p0);
                p1 = rev8(p1);
            end
            sbq.push_back({8'(2*j), expv[p1], expv[p0]});
        end
        readout = 1'b1; bitrev_en = brev;
        tick();
        readout = 1'b0; bitrev_en = 1'b0;
        check("valid_lat_e0", 40'(dout_valid), 40'd0);
        dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        tick();
        check("valid_lat_e1", 40'(dout_valid), 40'd1);
        guard = 0;
        while (done_cnt == d0 && guard < 3000) begin
            if (abort_at >= 0 && acc_cnt >= abort_at) break;
            dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            guard++;
        end
        if (abort_at >= 0) begin
            reset = 1'b1; dout_ready = 1'b0;
            tick();
            reset = 1'b0;
            sbq.delete();
            check("abort_valid", 40'(dout_valid), 40'd0);
            check("abort_idle_ready", 40'(din_ready), 40'd0);
            check("abort_full", 40'(full), 40'd0);
            repeat (5) tick();
            check("abort_no_done", 40'(done_cnt), 40'(d0));
            return;
        end
        if (guard >= 3000) begin
            total++; bad++;
            $display("FAIL drain_timeout actual=%0d required=%0d", acc_cnt, NB);
        end
        dout_ready = 1'b1;
        repeat (3) tick();
        check("done_once", 40'(done_cnt), 40'(d0 + 1));
        check("beats_accepted", 40'(acc_cnt), 40'(NB));
        check("scoreboard_empty", 40'(sbq.size()), 40'd0);
        check("drain_end_full", 40'(full), 40'd0);
        check("drain_end_valid", 40'(dout_valid), 40'd0);
        check("drain_end_idle", 40'(din_ready), 40'd0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            coef[i] = 16'(i);
            expv[i] = 16'(i);
        end
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_din_ready", 40'(din_ready), 40'd0);
        check("rst_dout_valid", 40'(dout_valid), 40'd0);
        check("rst_dout", 40'(dout), 40'd0);
        check("rst_out_index", 40'(out_index), 40'd0);
        check("rst_full", 40'(full), 40'd0);
        check("rst_done", 40'(done), 40'd0);
        check("rst_err", 40'(err), 40'd0);

        // Natural order
        load(1'b0, 1'b0, 1'b0);
        drain(1'b0, 1'b0, -1);
        check("nat_beat0", 40'(got[0]), 40'h0001_0000);
        check("nat_beat5", 40'(got[5]), 40'h000B_000A);
        check("nat_beat127", 40'(got[127]), 40'h00FF_00FE);

        // Bit-reversed order
        load(1'b0, 1'b0, 1'b0);
        drain(1'b1, 1'b0, -1);
        check("rev_beat0", 40'(got[0]), 40'h0080_0000);
        check("rev_beat1", 40'(got[1]), 40'h00C0_0040);
        check("rev_beat127", 40'(got[127]), 40'h00FF_007F);

        // Reduction and sticky error
        coef[0] = 16'd3328; coef[1] = 16'd3329; coef[2] = 16'd6657; coef[3] = 16'd6658;
        expv[0] = 16'd3328; expv[1] = 16'd0;    expv[2] = 16'd3328; expv[3] = 16'd3329;
        load(1'b1, 1'b0, 1'b0);
        check("err_after_beat0", 40'(err_trace[0]), 40'd0);
        check("err_after_beat1", 40'(err_trace[1]), 40'd1);
        check("err_after_load", 40'(err), 40'd1);
        drain(1'b0, 1'b0, -1);
        check("red_beat0", 40'(got[0]), 40'h0000_0D00);
        check("red_beat1", 40'(got[1]), 40'h0D01_0D00);
        check("err_sticky", 40'(err), 40'd1);

        // Random backpressure
        for (int i = 0; i < 4; i++) begin
            coef[i] = 16'(i);
            expv[i] = 16'(i);
        end
        load(1'b0, 1'b0, 1'b0);
        drain(1'b0, 1'b1, -1);

        // Input gaps, then set+readout together in FULL reloads instead of draining
        load(1'b0, 1'b1, 1'b0);
        load(1'b0, 1'b0, 1'b1);
        drain(1'b0, 1'b0, -1);

        // Reset during drain, then a clean full cycle
        load(1'b0, 1'b0, 1'b0);
        drain(1'b0, 1'b0, 40);
        load(1'b0, 1'b0, 1'b0);
        drain(1'b1, 1'b0, -1);
        check("post_reset_rev_beat1", 40'(got[1]), 40'h00C0_0040);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
